// File: rtl/stdp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stdp_pkg
//  Description : Sweep FSM state encoding plus the saturating add/subtract
//                and clamp helpers shared by the STDP scheduler blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package stdp_pkg;

    // Helpers work on a 64-bit container so any datapath width up to 63 bits
    // can be saturated without overflow of the intermediate sum.
    localparam int unsigned WIDE_W = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;
    typedef logic signed [WIDE_W:0]   ext_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_FIN   = 3'd5
    } stdp_state_e;

    function automatic wide_t sext(input logic [WIDE_W-1:0] v, input int unsigned n);
        wide_t t;
        t = wide_t'(v << (WIDE_W - n));
        return t >>> (WIDE_W - n);
    endfunction

    function automatic wide_t sat_fit(input ext_t x, input int unsigned n);
        ext_t one;
        ext_t hi;
        ext_t lo;
        one = ext_t'(1);
        hi  = (one <<< (n - 1)) - one;
        lo  = -(one <<< (n - 1));
        if (x > hi) begin
            return hi[WIDE_W-1:0];
        end else if (x < lo) begin
            return lo[WIDE_W-1:0];
        end
        return x[WIDE_W-1:0];
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned n);
        return sat_fit(ext_t'(a) + ext_t'(b), n);
    endfunction

    function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int unsigned n);
        return sat_fit(ext_t'(a) - ext_t'(b), n);
    endfunction

    function automatic wide_t clamp(input wide_t x, input wide_t lo, input wide_t hi);
        if (x < lo) begin
            return lo;
        end else if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_clamp.sv
`default_nettype none
// ============================================================================
//  Module      : sat_clamp
//  Description : Saturating signed add followed by a [lo, hi] clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_clamp
    import stdp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_lo,
    input  logic [N-1:0] i_hi,
    output logic [N-1:0] o_y
);

    wide_t w_sum;
    wide_t w_res;

    always_comb begin
        w_sum = sat_add(sext(64'(i_a), N), sext(64'(i_b), N), N);
        w_res = clamp(w_sum, sext(64'(i_lo), N), sext(64'(i_hi), N));
        o_y   = N'(w_res);
    end

endmodule
`default_nettype wire

// File: rtl/stdp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : stdp_scheduler
//  Description : Sweeps every synapse once per start pulse, requests a weight
//                change from the external STDP datapath and writes it back.
//  Revision    : 1.0 - initial release
// ============================================================================
module stdp_scheduler
    import stdp_pkg::*;
#(
    parameter int N       = 32,
    parameter int FRAC    = 16,
    parameter int NUM_SYN = 16,
    parameter int AW      = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  t_post,
    input  logic [N-1:0]  w_min,
    input  logic [N-1:0]  w_max,
    output logic [AW-1:0] syn_addr,
    input  logic [N-1:0]  pre_time,
    input  logic          pre_valid,
    input  logic [N-1:0]  w_rdata,
    output logic [N-1:0]  w_wdata,
    output logic          w_we,
    output logic [N-1:0]  dp_t_change,
    output logic          dp_apply,
    input  logic [N-1:0]  dp_dw,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SYN - 1);

    if ((FRAC >= N) || (N > 63) || (NUM_SYN < 1) || (NUM_SYN > 256)) begin : g_param_check
        $error("stdp_scheduler: illegal parameter combination");
    end

    stdp_state_e   state_q,  state_d;
    logic [AW-1:0] idx_q,    idx_d;
    logic [N-1:0]  t_post_q, t_post_d;
    logic [N-1:0]  w_q,      w_d;
    logic [N-1:0]  dw_q,     dw_d;

    logic          w_last;
    logic          w_advance;
    logic [N-1:0]  w_new_weight;
    wide_t         w_t_diff;

    assign w_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        t_post_d  = t_post_q;
        w_d       = w_q;
        dw_d      = dw_q;
        w_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    t_post_d = t_post;
                    idx_d    = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                if (pre_valid) begin
                    w_d     = w_rdata;
                    state_d = ST_WAIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_WAIT: begin
                dw_d    = dp_dw;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                w_advance = 1'b1;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_advance) begin
            if (w_last) begin
                state_d = ST_FIN;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_READ;
            end
        end

        // Abort overrides every other transition out of a busy state.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            t_post_q <= '0;
            w_q      <= '0;
            dw_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            t_post_q <= t_post_d;
            w_q      <= w_d;
            dw_q     <= dw_d;
        end
    end

    sat_clamp #(
        .N (N)
    ) u_sat_clamp (
        .i_a  (w_q),
        .i_b  (dw_q),
        .i_lo (w_min),
        .i_hi (w_max),
        .o_y  (w_new_weight)
    );

    assign w_t_diff = sat_sub(sext(64'(t_post_q), N), sext(64'(pre_time), N), N);

    // Outputs decode straight from the registered state, so an asynchronous
    // reset drops them all in the same instant it clears the FSM.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_FIN) && !abort;
        syn_addr    = idx_q;
        dp_apply    = (state_q == ST_CALC) && pre_valid;
        dp_t_change = dp_apply ? N'(w_t_diff) : '0;
        w_we        = (state_q == ST_WRITE) && !abort;
        w_wdata     = (state_q == ST_WRITE) ? w_new_weight : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_stdp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stdp_scheduler
//  Description : Scoreboard bench for stdp_scheduler with a 4-synapse memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stdp_scheduler;

    localparam int N    = 32;
    localparam int NSYN = 4;
    localparam int AW   = 2;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic [N-1:0]  t_post = '0;
    logic [N-1:0]  w_min  = 32'd0;
    logic [N-1:0]  w_max  = 32'd1000;
    logic [AW-1:0] syn_addr;
    logic [N-1:0]  pre_time;
    logic          pre_valid;
    logic [N-1:0]  w_rdata;
    logic [N-1:0]  w_wdata;
    logic          w_we;
    logic [N-1:0]  dp_t_change;
    logic          dp_apply;
    logic [N-1:0]  dp_dw;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    stdp_scheduler #(
        .N       (N),
        .FRAC    (16),
        .NUM_SYN (NSYN),
        .AW      (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .t_post      (t_post),
        .w_min       (w_min),
        .w_max       (w_max),
        .syn_addr    (syn_addr),
        .pre_time    (pre_time),
        .pre_valid   (pre_valid),
        .w_rdata     (w_rdata),
        .w_wdata     (w_wdata),
        .w_we        (w_we),
        .dp_t_change (dp_t_change),
        .dp_apply    (dp_apply),
        .dp_dw       (dp_dw),
        .busy        (busy),
        .done        (done)
    );

    // Synchronous memories and a datapath stub with one-cycle latency.
    logic [N-1:0]    pre_mem [NSYN];
    logic [N-1:0]    dw_mem  [NSYN];
    logic [N-1:0]    w_init  [NSYN];
    logic [N-1:0]    w_mem   [NSYN];
    logic [NSYN-1:0] val_mem = '0;
    logic            load_w  = 1'b0;

    always @(posedge clk) begin
        pre_time  <= pre_mem[syn_addr];
        pre_valid <= val_mem[syn_addr];
        w_rdata   <= w_mem[syn_addr];
        dp_dw     <= dp_apply ? dw_mem[syn_addr] : 32'hDEAD_BEEF;
        if (load_w) begin
            for (int i = 0; i < NSYN; i++) w_mem[i] <= w_init[i];
        end else if (w_we) begin
            w_mem[syn_addr] <= w_wdata;
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } wr_t;

    wr_t          wr_q [$];
    logic [N-1:0] tc_q [$];

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    int   read_start = 0;
    int   exp_lat    = 0;
    int   done_cnt   = 0;
    logic busy_prev  = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [N-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sat32(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic logic [N-1:0] exp_tc(input logic [N-1:0] tp, input logic [N-1:0] pre);
        longint d;
        d = sat32(sx(tp) - sx(pre));
        return d[N-1:0];
    endfunction

    function automatic logic [N-1:0] exp_wr(input logic [N-1:0] w, input logic [N-1:0] dw);
        longint s;
        s = sat32(sx(w) + sx(dw));
        if (s < sx(w_min)) s = sx(w_min);
        if (s > sx(w_max)) s = sx(w_max);
        return s[N-1:0];
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (busy && !busy_prev) read_start = cyc;
        busy_prev = busy;
        if (dp_apply && w_we) check_val("apply_we_overlap", 64'd1, 64'd0);
        if (dp_apply) begin
            if (tc_q.size() == 0) check_val("unexpected_apply", 64'd1, 64'd0);
            else check_val("dp_t_change", 64'(dp_t_change), 64'(tc_q.pop_front()));
        end
        if (w_we) begin
            if (wr_q.size() == 0) begin
                check_val("unexpected_write", 64'(syn_addr), 64'hFFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check_val("write_addr", 64'(syn_addr), 64'(e.addr));
                check_val("write_data", 64'(w_wdata), 64'(e.data));
            end
        end
        if (done) begin
            done_cnt++;
            check_val("done_latency", 64'(cyc - read_start), 64'(exp_lat));
        end
    end

    task automatic set_syn(input int i, input logic [N-1:0] pre, input logic v, input logic [N-1:0] dw);
        pre_mem[i] = pre;
        val_mem[i] = v;
        dw_mem[i]  = dw;
    endtask

    task automatic load_weights(input logic [N-1:0] w0, input logic [N-1:0] w1,
                                input logic [N-1:0] w2, input logic [N-1:0] w3);
        w_init[0] = w0; w_init[1] = w1; w_init[2] = w2; w_init[3] = w3;
        @(posedge clk); #1 load_w = 1'b1;
        @(posedge clk); #1 load_w = 1'b0;
    endtask

    // Pushes the expected transactions (limited to the first n_tc applies and
    // n_wr writes among valid synapses) and then pulses start.
    task automatic launch(input logic [N-1:0] tp, input int n_tc, input int n_wr);
        int nv;
        int lat;
        nv  = 0;
        lat = 0;
        for (int i = 0; i < NSYN; i++) begin
            lat += val_mem[i] ? 4 : 2;
            if (val_mem[i]) begin
                if (nv < n_tc) tc_q.push_back(exp_tc(tp, pre_mem[i]));
                if (nv < n_wr) wr_q.push_back('{addr: AW'(i), data: exp_wr(w_mem[i], dw_mem[i])});
                nv++;
            end
        end
        exp_lat = lat;
        @(posedge clk); #1;
        t_post = tp;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c0;
        bit seen;
        c0   = done_cnt;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done_cnt != c0) begin
                seen = 1'b1;
                break;
            end
        end
        check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_val({tag, "_wr_q_drained"}, 64'(wr_q.size()), 64'd0);
        check_val({tag, "_tc_q_drained"}, 64'(tc_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_w_we"}, 64'(w_we), 64'd0);
        check_val({tag, "_dp_apply"}, 64'(dp_apply), 64'd0);
        check_val({tag, "_syn_addr"}, 64'(syn_addr), 64'd0);
        check_val({tag, "_w_wdata"}, 64'(w_wdata), 64'd0);
        check_val({tag, "_dp_t_change"}, 64'(dp_t_change), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        bit   found;
        logic [N-1:0] w1_saved;

        for (int i = 0; i < NSYN; i++) begin
            set_syn(i, '0, 1'b0, '0);
            w_init[i] = '0;
        end
        #12;
        check_idle_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Full sweep, all valid; a stray start mid-sweep must be ignored.
        set_syn(0, 32'd10, 1'b1, 32'd5);
        set_syn(1, 32'd20, 1'b1, -32'sd7);
        set_syn(2, 32'd30, 1'b1, 32'd50);
        set_syn(3, 32'd40, 1'b1, 32'd0);
        load_weights(32'd100, 32'd200, 32'd300, 32'd400);
        launch(32'd100, 4, 4);
        repeat (5) @(posedge clk);
        #1 t_post = 32'd999; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("all_valid", 100);

        // Sparse sweep: only synapses 0 and 2 valid.
        set_syn(0, 32'd50, 1'b1, 32'd900);
        set_syn(1, 32'd60, 1'b0, 32'd3);
        set_syn(2, 32'd150, 1'b1, -32'sd400);
        set_syn(3, 32'd70, 1'b0, 32'd3);
        launch(32'd120, 4, 4);
        wait_done("sparse", 100);

        // Saturation and clamp corners.
        set_syn(0, 32'h8000_0000, 1'b1, 32'd50);
        set_syn(1, 32'h7FFF_FFFF, 1'b1, -32'sd20);
        set_syn(2, 32'd0, 1'b1, 32'h7FFF_FFFF);
        set_syn(3, 32'd3, 1'b0, 32'd1);
        load_weights(32'd990, 32'd5, 32'd500, 32'd7);
        launch(32'h7FFF_FFFF, 4, 4);
        wait_done("saturate", 100);

        // Abort in the WAIT state of synapse 2.
        for (int i = 0; i < NSYN; i++) set_syn(i, 32'(i + 1), 1'b1, 32'd1);
        launch(32'd50, 3, 2);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (dp_apply && (syn_addr == 2'd2)) begin
                found = 1'b1;
                break;
            end
        end
        check_val("abort_reach_syn2", 64'(found), 64'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check_val("abort_busy_low", 64'(busy), 64'd0);
        c0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check_val("abort_no_done", 64'(done_cnt), 64'(c0));
        check_val("abort_wr_q_drained", 64'(wr_q.size()), 64'd0);
        check_val("abort_tc_q_drained", 64'(tc_q.size()), 64'd0);

        // Reset asserted during the WRITE of synapse 1.
        load_weights(32'd10, 32'd20, 32'd30, 32'd40);
        launch(32'd60, 4, 4);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (w_we && (syn_addr == 2'd1)) begin
                found = 1'b1;
                break;
            end
        end
        check_val("reset_reach_write1", 64'(found), 64'd1);
        w1_saved = w_mem[1];
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        wr_q.delete();
        tc_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("reset_no_write", 64'(w_mem[1]), 64'(w1_saved));
        launch(32'd60, 4, 4);
        wait_done("after_reset", 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stdp_scheduler.md
STDP_SCHEDULER -- requirements
Module: stdp_scheduler

Interface
REQ-001 Parameters SHALL be: N, default 32, datapath word width; FRAC, default 16, fractional bits of the signed fixed-point format; NUM_SYN, default 16, synapse count (1..256); AW, default $clog2(NUM_SYN) (minimum 1), synapse address width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a sweep over all synapses.
- abort  in  1  one-cycle pulse that terminates the sweep.
- t_post  in  N  postsynaptic spike time, captured on start.
- w_min, w_max  in  N  weight clamp bounds, signed, w_min <= w_max.
- syn_addr  out  AW  synapse index for the pre-time and weight memories.
- pre_time  in  N  presynaptic spike time at syn_addr, valid 1 cycle after syn_addr.
- pre_valid  in  1  presynaptic spike recorded flag, same timing as pre_time.
- w_rdata  in  N  weight at syn_addr, same timing as pre_time.
- w_wdata  out  N  updated weight.
- w_we  out  1  weight write strobe, writes w_wdata at syn_addr.
- dp_t_change  out  N  time difference presented to the STDP datapath.
- dp_apply  out  1  datapath apply strobe.
- dp_dw  in  N  datapath weight change, valid 1 cycle after dp_apply.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at sweep end.

Function
REQ-003 The FSM SHALL use states IDLE, READ, CALC, WAIT, WRITE and FIN.
REQ-004 In IDLE, start SHALL latch t_post, clear the index to 0 and go to READ; start SHALL be ignored whenever busy is high.
REQ-005 In READ, syn_addr SHALL hold the current index; the next state SHALL be CALC.
REQ-006 In CALC, if pre_valid = 0 the synapse SHALL be skipped with no dp_apply and no w_we, and the FSM SHALL advance the index.
REQ-007 In CALC, if pre_valid = 1 the block SHALL drive dp_t_change = sat(t_post_latched - pre_time), assert dp_apply for exactly one cycle, latch w_rdata, and go to WAIT.
REQ-008 In WAIT, the block SHALL latch dp_dw and go to WRITE.
REQ-009 In WRITE, w_wdata SHALL equal clamp(sat(w + dw), w_min, w_max), w_we SHALL be high for exactly one cycle, and the FSM SHALL advance the index.
REQ-010 Advancing from index NUM_SYN-1 SHALL go to FIN; otherwise the index SHALL increment and the FSM SHALL go to READ.
REQ-011 Cycle cost SHALL be 4 cycles per valid synapse and 2 cycles per skipped synapse, measured from READ.
REQ-012 FIN SHALL pulse done for one cycle and then return to IDLE; busy SHALL be high in every state except IDLE.
REQ-013 All arithmetic SHALL be N-bit two's complement; sat() SHALL clamp to the most positive or most negative representable value on overflow, never wrap.
REQ-014 dp_t_change = 0 SHALL be passed unchanged; the datapath treats it as the potentiation case.
REQ-015 abort in any busy state SHALL force IDLE on the next edge, suppress any pending w_we, and produce no done pulse.
REQ-016 abort asserted in the same cycle as start while in IDLE SHALL win, leaving the FSM in IDLE.
REQ-017 dp_apply and w_we SHALL never be high in the same cycle.
REQ-018 syn_addr SHALL remain stable from READ through WRITE for each synapse.

Reset
REQ-019 rst_n low SHALL immediately force state IDLE and clear index, busy, done, w_we, dp_apply, syn_addr, w_wdata and dp_t_change to 0, including mid-sweep.
REQ-020 No memory write SHALL occur in the cycle rst_n deasserts.

Structure
REQ-021 The FSM state enum and the saturating add/subtract and clamp functions SHALL live in a shared package, stdp_pkg.
REQ-022 One sub-module, sat_clamp (saturating add followed by min/max clamp), SHALL compute w_wdata.
REQ-023 The STDP datapath SHALL be instantiated outside this block.

Verification
REQ-024 The bench SHALL cover the following directed scenarios (values are raw N=32 integers; w_min = 0 and w_max = 1000 unless stated):
- NUM_SYN = 4, all pre_valid = 1, start -> 4 apply/write pairs, done exactly 16 cycles after READ entry.
- pre_valid = 0101 (binary) -> writes only at addresses 0 and 2, done 12 cycles after READ entry.
- t_post = 0x7FFFFFFF, pre_time = 0x80000000 -> dp_t_change = 0x7FFFFFFF (saturated).
- w = 990, dp_dw = 50 -> w_wdata = 1000; w = 5, dp_dw = -20 -> w_wdata = 0.
- abort during WAIT of synapse 2 -> no w_we at address 2, no done pulse, busy low the next cycle; start while busy -> ignored.
- rst_n pulsed low during WRITE -> w_we drops immediately, all outputs 0; a subsequent start runs a full, correct sweep.
